// File: rtl/sram_like_arbiter_pkg.sv
// Shared bus definitions for the SRAM-like arbiter: default widths, channel indices, size codes.
package sram_like_arbiter_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    localparam int CH_DATA = 0;
    localparam int CH_INST = 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of channel IDs for outstanding SRAM-like transactions.
module sram_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like bus arbiter with in-order response routing.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = BUS_AW,
    parameter int DW    = BUS_DW,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [NCH*DW/8-1:0]   m_wstrb,
    input  logic [NCH*AW-1:0]     m_addr,
    input  logic [NCH*DW-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [DW-1:0]         m_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [DW/8-1:0]       s_wstrb,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [DW-1:0]         s_rdata,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = $clog2(NCH);
    localparam int SW = DW / 8;
    localparam int QW = $clog2(DEPTH) + 1;

    logic [CW-1:0] grant;
    logic [CW-1:0] arb_grant;
    logic [CW-1:0] lock_ch;
    logic [CW-1:0] head;
    logic          lock_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic [QW-1:0] fifo_count;
    logic          handshake;
    logic          pop;

`ifdef ARB_RR_EN
    logic [CW-1:0] rr_ptr;
    logic          found;
    int            idx;

    always_ff @(posedge clk) begin
        if (reset)          rr_ptr <= '0;
        else if (handshake) rr_ptr <= CW'(wrap_inc(int'(grant), NCH));
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        arb_grant = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!found && m_req[idx]) begin
                found     = 1'b1;
                arb_grant = CW'(idx);
            end
        end
    end
`else
    always_comb begin
        arb_grant = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m_req[i]) arb_grant = CW'(i);
        end
    end
`endif

    // A stalled request keeps its channel so the slave sees stable fields.
    assign grant     = (lock_valid && m_req[lock_ch]) ? lock_ch : arb_grant;
    assign s_req     = (|m_req) & ~fifo_full & ~reset;
    assign handshake = s_req & s_addr_ok;
    assign pop       = s_data_ok & ~fifo_empty & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_ch    <= '0;
        end else begin
            lock_valid <= s_req & ~s_addr_ok;
            lock_ch    <= grant;
        end
    end

    always_comb begin
        s_wr    = m_wr[grant];
        s_size  = m_size[2*int'(grant) +: 2];
        s_wstrb = m_wstrb[int'(grant)*SW +: SW];
        s_addr  = m_addr[int'(grant)*AW +: AW];
        s_wdata = m_wdata[int'(grant)*DW +: DW];
    end

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (handshake) m_addr_ok[grant] = 1'b1;
        if (pop)       m_data_ok[head]  = 1'b1;
    end

    assign m_rdata = s_rdata;
    assign busy    = (fifo_count != '0) & ~reset;

    always_ff @(posedge clk) begin
        if (reset)                        err <= 1'b0;
        else if (s_data_ok && fifo_empty) err <= 1'b1;
    end

    sram_id_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (handshake),
        .pop   (pop),
        .din   (grant),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: vector table, directed corner sequences, random vs. model.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int NCH   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = DW / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH-1:0]      m_req;
    logic [NCH-1:0]      m_wr;
    logic [2*NCH-1:0]    m_size;
    logic [NCH*SW-1:0]   m_wstrb;
    logic [NCH*AW-1:0]   m_addr;
    logic [NCH*DW-1:0]   m_wdata;
    logic [NCH-1:0]      m_addr_ok;
    logic [NCH-1:0]      m_data_ok;
    logic [DW-1:0]       m_rdata;
    logic                s_req;
    logic                s_wr;
    logic [1:0]          s_size;
    logic [SW-1:0]       s_wstrb;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;
    logic                s_addr_ok;
    logic                s_data_ok;
    logic [DW-1:0]       s_rdata;
    logic                busy;
    logic                err;

    sram_like_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] ch_addr  [NCH];
    logic [DW-1:0] ch_wdata [NCH];
    logic          ch_wr    [NCH];
    logic [1:0]    ch_size  [NCH];
    logic [SW-1:0] ch_wstrb [NCH];

    typedef struct {
        logic [NCH-1:0] req;
        logic           aok;
        logic           exp_sreq;
        logic [NCH-1:0] exp_aok;
        int             exp_ch;
    } vec_t;

    vec_t vecs[6];

    // Reference model state
    int mq[$];
    bit m_lock;
    int m_lock_ch;
    int m_ptr;
    bit m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic pack_fields();
        for (int c = 0; c < NCH; c++) begin
            m_addr[c*AW +: AW]  = ch_addr[c];
            m_wdata[c*DW +: DW] = ch_wdata[c];
            m_wr[c]             = ch_wr[c];
            m_size[2*c +: 2]    = ch_size[c];
            m_wstrb[c*SW +: SW] = ch_wstrb[c];
        end
    endtask

    task automatic fixed_fields();
        ch_addr[0] = 32'h1000_0000; ch_wdata[0] = 32'hA5A5_0000; ch_wr[0] = 1'b1;
        ch_size[0] = SZ_WORD;       ch_wstrb[0] = 4'hF;
        ch_addr[1] = 32'h2000_0004; ch_wdata[1] = 32'h5A5A_1111; ch_wr[1] = 1'b0;
        ch_size[1] = SZ_HALF;       ch_wstrb[1] = 4'h3;
        pack_fields();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        tick();
        reset = 1'b0;
        mq.delete();
        m_lock = 0; m_lock_ch = 0; m_ptr = 0; m_err = 0;
    endtask

    function automatic int model_pick(input logic [NCH-1:0] req, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return 0;
    endfunction

    int             pulses;
    logic [NCH-1:0] exp_rr [4];
    logic [NCH-1:0] e_aok;
    logic [NCH-1:0] e_dok;
    bit             e_sreq;
    int             g;

    initial begin
        fixed_fields();
        s_rdata = '0;

        // Reset holds all handshakes low even with live inputs
        reset = 1'b1; m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        settle();
        check("rst_s_req", s_req, 0);
        check("rst_addr_ok", m_addr_ok, 0);
        check("rst_data_ok", m_data_ok, 0);
        check("rst_busy", busy, 0);
        tick();
        reset = 1'b0; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        settle();
        check("rst_err", err, 0);
        check("rst_busy_after", busy, 0);
        tick();

        // Single-cycle grant/handshake table from an idle arbiter
        vecs[0] = '{2'b00, 1'b1, 1'b0, 2'b00, 0};
        vecs[1] = '{2'b01, 1'b1, 1'b1, 2'b01, 0};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 2'b10, 1};
        vecs[3] = '{2'b11, 1'b1, 1'b1, 2'b01, 0};
        vecs[4] = '{2'b11, 1'b0, 1'b1, 2'b00, 0};
        vecs[5] = '{2'b10, 1'b0, 1'b1, 2'b00, 1};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            m_req = vecs[i].req; s_addr_ok = vecs[i].aok;
            settle();
            check($sformatf("vec%0d_s_req", i), s_req, vecs[i].exp_sreq);
            check($sformatf("vec%0d_addr_ok", i), m_addr_ok, vecs[i].exp_aok);
            if (vecs[i].exp_sreq) begin
                check($sformatf("vec%0d_s_addr", i), s_addr, ch_addr[vecs[i].exp_ch]);
                check($sformatf("vec%0d_s_ctl", i), {s_wr, s_size, s_wstrb},
                      {ch_wr[vecs[i].exp_ch], ch_size[vecs[i].exp_ch], ch_wstrb[vecs[i].exp_ch]});
                check($sformatf("vec%0d_s_wdata", i), s_wdata, ch_wdata[vecs[i].exp_ch]);
            end
            tick();
        end

        // Single read on ch1, response two cycles after accept
        do_reset();
        m_req = 2'b10; s_addr_ok = 1'b1;
        settle(); check("rd1_addr_ok", m_addr_ok, 2'b10); tick();
        m_req = 2'b00; s_addr_ok = 1'b0;
        settle(); check("rd1_addr_ok_low", m_addr_ok, 2'b00); check("rd1_busy", busy, 1); tick();
        s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle(); check("rd1_data_ok", m_data_ok, 2'b10); check("rd1_rdata", m_rdata, 32'hDEAD_BEEF); tick();
        s_data_ok = 1'b0;
        settle(); check("rd1_busy_done", busy, 0); tick();

        // Simultaneous requests, fixed/initial priority, in-order routing
        do_reset();
        m_req = 2'b11; s_addr_ok = 1'b1;
        settle(); check("sim_first", m_addr_ok, 2'b01); tick();
        m_req = 2'b10;
        settle(); check("sim_second", m_addr_ok, 2'b10); tick();
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h11;
        settle(); check("sim_resp0", m_data_ok, 2'b01); check("sim_rdata0", m_rdata, 32'h11); tick();
        s_rdata = 32'h22;
        settle(); check("sim_resp1", m_data_ok, 2'b10); check("sim_rdata1", m_rdata, 32'h22); tick();
        s_data_ok = 1'b0;
        settle(); check("sim_idle", busy, 0); tick();

        // Lock: ch1 stalled, ch0 arrives, grant must not move
        do_reset();
        m_req = 2'b10; s_addr_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_req = 2'b11;
            settle();
            check($sformatf("lock_addr_c%0d", c + 1), s_addr, ch_addr[1]);
            check($sformatf("lock_aok_c%0d", c + 1), m_addr_ok, 2'b00);
            tick();
        end
        s_addr_ok = 1'b1;
        settle(); check("lock_accept_c4", m_addr_ok, 2'b10); tick();
        m_req = 2'b01;
        settle(); check("lock_next_ch0", m_addr_ok, 2'b01); tick();

        // Lock clears when the locked master withdraws
        do_reset();
        m_req = 2'b10; s_addr_ok = 1'b0; settle(); tick();
        m_req = 2'b00; settle(); tick();
        m_req = 2'b11; settle(); check("lock_drop_addr", s_addr, ch_addr[0]); tick();

        // Fill to DEPTH with no responses, then one pop re-enables one accept
        do_reset();
        m_req = 2'b01; s_addr_ok = 1'b1; pulses = 0;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (m_addr_ok[0]) pulses++;
            tick();
        end
        check("full_pulses", pulses, DEPTH);
        settle(); check("full_s_req", s_req, 0); tick();
        s_data_ok = 1'b1; s_rdata = 32'h33;
        settle();
        check("full_pop_s_req", s_req, 0);
        check("full_pop_aok", m_addr_ok, 2'b00);
        check("full_pop_dok", m_data_ok, 2'b01);
        tick();
        s_data_ok = 1'b0;
        settle(); check("full_reaccept", m_addr_ok, 2'b01); tick();
        settle(); check("full_again", s_req, 0); tick();

        // Reset with outstanding IDs; a stray data_ok then flags err
        do_reset();
        settle(); check("flush_busy", busy, 0); tick();
        s_data_ok = 1'b1;
        settle(); check("stray_dok", m_data_ok, 2'b00); check("stray_err_pre", err, 0); tick();
        s_data_ok = 1'b0;
        settle(); check("stray_err", err, 1); tick();
        tick();
        settle(); check("stray_err_sticky", err, 1); tick();
        do_reset();
        settle(); check("err_cleared", err, 0); tick();

        // Continuous requests from both channels
`ifdef ARB_RR_EN
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        m_req = 2'b11; s_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("both_grant%0d", c), m_addr_ok, exp_rr[c]);
            tick();
        end

        // Random traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_addr[c]  = $urandom;
                ch_wdata[c] = $urandom;
                ch_wr[c]    = 1'($urandom_range(0, 1));
                ch_size[c]  = 2'($urandom_range(0, 2));
                ch_wstrb[c] = SW'($urandom);
            end
            pack_fields();
            m_req     = NCH'($urandom_range(0, 3));
            s_addr_ok = ($urandom_range(0, 2) != 0);
            s_data_ok = ($urandom_range(0, 3) == 0);
            s_rdata   = $urandom;
            settle();

            e_sreq = (m_req != 0) && (mq.size() < DEPTH);
            g      = (m_lock && m_req[m_lock_ch]) ? m_lock_ch : model_pick(m_req, m_ptr);
            e_aok  = '0;
            e_dok  = '0;
            if (e_sreq && s_addr_ok) e_aok[g] = 1'b1;
            if (s_data_ok && mq.size() > 0) e_dok[mq[0]] = 1'b1;

            check("rnd_s_req", s_req, e_sreq);
            check("rnd_addr_ok", m_addr_ok, e_aok);
            check("rnd_data_ok", m_data_ok, e_dok);
            check("rnd_busy", busy, mq.size() > 0);
            check("rnd_err", err, m_err);
            if (e_sreq) check("rnd_s_addr", s_addr, ch_addr[g]);
            if (e_dok != 0) check("rnd_rdata", m_rdata, s_rdata);

            if (s_data_ok) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else               m_err = 1;
            end
            if (e_sreq && s_addr_ok) begin
                mq.push_back(g);
`ifdef ARB_RR_EN
                m_ptr = (g + 1) % NCH;
`endif
            end
            m_lock    = e_sreq && !s_addr_ok;
            m_lock_ch = g;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
